// File: rtl/alu_cmd_ctrl_if.sv
// Command/response valid-ready bundle between a command source and alu_cmd_ctrl.
// ALU_CHAIN_EN adds the cmd_chain request bit.
interface alu_cmd_ctrl_if #(
  parameter int unsigned OPCODE_WIDTH = 2,
  parameter int unsigned DATA_WIDTH   = 3,
  parameter int unsigned TAG_WIDTH    = 4
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [OPCODE_WIDTH:0]   cmd_opcode;
  logic [DATA_WIDTH:0]     cmd_op1;
  logic [DATA_WIDTH:0]     cmd_op2;
  logic [TAG_WIDTH-1:0]    cmd_tag;
`ifdef ALU_CHAIN_EN
  logic                    cmd_chain;
`endif

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH:0]     rsp_result;
  logic                    rsp_carry;
  logic                    rsp_zero;
  logic [TAG_WIDTH-1:0]    rsp_tag;

`ifdef ALU_CHAIN_EN
  modport master (
    output cmd_valid, cmd_opcode, cmd_op1, cmd_op2, cmd_tag, cmd_chain, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_tag
  );
  modport slave (
    input  cmd_valid, cmd_opcode, cmd_op1, cmd_op2, cmd_tag, cmd_chain, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_tag
  );
`else
  modport master (
    output cmd_valid, cmd_opcode, cmd_op1, cmd_op2, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_tag
  );
  modport slave (
    input  cmd_valid, cmd_opcode, cmd_op1, cmd_op2, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_tag
  );
`endif
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Single-outstanding command sequencer for a registered ALU: drive operands, wait the ALU
// latency, capture the result and return it tagged. ALU_CHAIN_EN enables accumulator chaining.
module alu_cmd_ctrl #(
  parameter int unsigned OPCODE_WIDTH = 2,
  parameter int unsigned DATA_WIDTH   = 3,
  parameter int unsigned ALU_LATENCY  = 1,
  parameter int unsigned TAG_WIDTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_cmd_ctrl_if.slave         bus,
  output logic [OPCODE_WIDTH:0] alu_opcode,
  output logic [DATA_WIDTH:0]   alu_op1,
  output logic [DATA_WIDTH:0]   alu_op2,
  input  logic [DATA_WIDTH:0]   alu_result,
  input  logic                  alu_carry,
  input  logic                  alu_zero,
  output logic                  busy,
  output logic [7:0]            op_count
);

  localparam int unsigned CntW = (ALU_LATENCY < 2) ? 1 : $clog2(ALU_LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic                  cmd_ready_q;
  logic                  rsp_valid_q;
  logic                  busy_q;
  logic [7:0]            op_count_q;
  logic [OPCODE_WIDTH:0] alu_opcode_q;
  logic [DATA_WIDTH:0]   alu_op1_q;
  logic [DATA_WIDTH:0]   alu_op2_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [DATA_WIDTH:0]   rsp_result_q;
  logic                  rsp_carry_q;
  logic                  rsp_zero_q;
  logic [DATA_WIDTH:0]   op1_sel;

`ifdef ALU_CHAIN_EN
  logic [DATA_WIDTH:0]   acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (state_q == StWait && cnt_q == '0) begin
      acc_q <= alu_result;
    end
  end

  assign op1_sel = bus.cmd_chain ? acc_q : bus.cmd_op1;
`else
  assign op1_sel = bus.cmd_op1;
`endif

  // cmd_ready is a registered decode of "next state is idle", so it stays low during reset
  // and rises one edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      op_count_q   <= '0;
      alu_opcode_q <= '0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      tag_q        <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            alu_opcode_q <= bus.cmd_opcode;
            alu_op1_q    <= op1_sel;
            alu_op2_q    <= bus.cmd_op2;
            tag_q        <= bus.cmd_tag;
            cnt_q        <= CntW'(ALU_LATENCY);
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= StWait;
          end else begin
            cmd_ready_q  <= 1'b1;
          end
        end
        StWait: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            rsp_result_q <= alu_result;
            rsp_carry_q  <= alu_carry;
            rsp_zero_q   <= alu_zero;
            rsp_valid_q  <= 1'b1;
            state_q      <= StResp;
          end
        end
        StResp: begin
          // Response data is left in place after the handshake; only valid drops.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + 8'd1;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_tag    = tag_q;

  assign alu_opcode = alu_opcode_q;
  assign alu_op1    = alu_op1_q;
  assign alu_op2    = alu_op2_q;
  assign busy       = busy_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Scoreboard bench for alu_cmd_ctrl with a behavioural registered ALU (latency 1) attached.
// Directed reset/add/sub/backpressure/reset-mid-wait cases, then randomized traffic.
module tb_alu_cmd_ctrl;
  localparam int unsigned OW  = 2;
  localparam int unsigned DW  = 3;
  localparam int unsigned LAT = 1;
  localparam int unsigned TW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_cmd_ctrl_if #(.OPCODE_WIDTH(OW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  logic [OW:0] alu_opcode;
  logic [DW:0] alu_op1, alu_op2, alu_result;
  logic        alu_carry, alu_zero, busy;
  logic [7:0]  op_count;

  alu_cmd_ctrl #(
    .OPCODE_WIDTH(OW), .DATA_WIDTH(DW), .ALU_LATENCY(LAT), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .busy(busy), .op_count(op_count)
  );

  // ALU behaviour: {carry, zero, result}; carry is overflow/borrow of the arithmetic ops.
  function automatic logic [DW+2:0] alu_ref(input logic [OW:0] opc, input logic [DW:0] a,
                                            input logic [DW:0] b);
    int          r;
    int          m;
    logic        c;
    logic [DW:0] res;
    m = 1 << (DW + 1);
    case (opc)
      3'd0:    r = int'(a) + int'(b);
      3'd1:    r = int'(a) - int'(b);
      3'd2:    r = int'(a) + 1;
      3'd3:    r = int'(a) - 1;
      3'd4:    r = int'(a & b);
      3'd5:    r = int'(a | b);
      3'd6:    r = int'(~(a & b));
      default: r = int'(a ^ b);
    endcase
    c   = (opc <= 3'd3) && (r < 0 || r >= m);
    res = r[DW:0];
    return {c, res == '0, res};
  endfunction

  always @(posedge clk) {alu_carry, alu_zero, alu_result} <= alu_ref(alu_opcode, alu_op1, alu_op2);

  typedef struct {
    logic [DW:0]   op1;
    logic [DW:0]   res;
    logic          c;
    logic          z;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cnt_model = 0;
  logic [DW:0] acc_model = '0;
  int          wait_cnt = 0;
  bit          seen_valid = 1'b0;
  bit          inflight = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor/scoreboard: samples on the falling edge, inputs change just after rising edges.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      cnt_model  = 0;
      acc_model  = '0;
      inflight   = 1'b0;
    end else begin
      check("op_count", op_count, cnt_model & 255);
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding, expected 0");
        end else begin
          if (!seen_valid) begin
            check("latency", wait_cnt, LAT + 1);
            seen_valid = 1'b1;
          end
          check("rsp_result", bus.rsp_result, q[0].res);
          check("rsp_carry", bus.rsp_carry, q[0].c);
          check("rsp_zero", bus.rsp_zero, q[0].z);
          check("rsp_tag", bus.rsp_tag, q[0].tag);
          check("alu_op1_held", alu_op1, q[0].op1);
          check("cmd_ready_in_resp", bus.cmd_ready, 0);
          check("busy_in_resp", busy, 1);
          if (bus.rsp_ready) begin
            void'(q.pop_front());
            cnt_model++;
            inflight = 1'b0;
          end
        end
      end else if (inflight) begin
        wait_cnt++;
        check("busy_in_wait", busy, 1);
        if (wait_cnt > 50) begin
          checks++;
          errors++;
          $display("FAIL rsp_timeout: no rsp_valid after %0d cycles, expected %0d", wait_cnt,
                   LAT + 1);
          inflight = 1'b0;
          q.delete();
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        exp_t        e;
        logic [DW+2:0] r;
        e.op1 = bus.cmd_op1;
`ifdef ALU_CHAIN_EN
        if (bus.cmd_chain) e.op1 = acc_model;
`endif
        r     = alu_ref(bus.cmd_opcode, e.op1, bus.cmd_op2);
        e.c   = r[DW+2];
        e.z   = r[DW+1];
        e.res = r[DW:0];
        e.tag = bus.cmd_tag;
        acc_model = e.res;
        q.push_back(e);
        inflight   = 1'b1;
        seen_valid = 1'b0;
        wait_cnt   = 0;
      end
    end
  end

  task automatic send(input logic [OW:0] opc, input logic [DW:0] a, input logic [DW:0] b,
                      input logic [TW-1:0] tag, input bit chain);
    bit ok;
    int guard;
    ok    = 1'b0;
    guard = 0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = opc;
    bus.cmd_op1    = a;
    bus.cmd_op2    = b;
    bus.cmd_tag    = tag;
`ifdef ALU_CHAIN_EN
    bus.cmd_chain  = chain;
`else
    if (chain) guard = 0;
`endif
    do begin
      @(negedge clk);
      ok = bus.cmd_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!ok && guard < 200);
    bus.cmd_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: cmd_ready stayed 0, expected 1");
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((q.size() != 0 || bus.rsp_valid) && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  bit done;

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_opcode = '0;
    bus.cmd_op1    = '0;
    bus.cmd_op2    = '0;
    bus.cmd_tag    = '0;
`ifdef ALU_CHAIN_EN
    bus.cmd_chain  = 1'b0;
`endif
    bus.rsp_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 0);
    check("rst_alu_opcode", alu_opcode, 0);
    check("rst_alu_op1", alu_op1, 0);
    check("rst_alu_op2", alu_op2, 0);
    check("rst_rsp_result", bus.rsp_result, 0);
    check("rst_rsp_tag", bus.rsp_tag, 0);
    rst = 1'b0;
    check("cmd_ready_at_release", bus.cmd_ready, 0);
    @(posedge clk);
    #1;
    check("cmd_ready_after_edge", bus.cmd_ready, 1);

    bus.rsp_ready = 1'b1;
    send(3'd0, 4'd10, 4'd10, 4'd3, 1'b0);
    wait_idle();
    check("op_count_after_add", op_count, 1);
    send(3'd1, 4'd5, 4'd5, 4'd9, 1'b0);
    wait_idle();

    // Backpressure with a competing command held valid.
    bus.rsp_ready = 1'b0;
    send(3'd7, 4'd6, 4'd3, 4'd12, 1'b0);
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = 3'd5;
    bus.cmd_tag    = 4'd1;
    for (int i = 0; i < 20 && !bus.rsp_valid; i++) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_cmd_ready", bus.cmd_ready, 0);
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_idle();
    check("op_count_after_bp", op_count, 3);

    // Reset while waiting on the ALU drops the operation.
    send(3'd2, 4'd4, 4'd0, 4'd5, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_op_count", op_count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_rsp_valid", bus.rsp_valid, 0);
    check("post_rst_op_count", op_count, 0);

`ifdef ALU_CHAIN_EN
    send(3'd2, 4'd15, 4'd0, 4'd2, 1'b0);
    wait_idle();
    send(3'd2, 4'd9, 4'd0, 4'd4, 1'b1);
    wait_idle();
    check("chain_alu_op1", alu_op1, 0);
    check("chain_result", bus.rsp_result, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
`endif

    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom),
               1'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.rsp_ready = 1'b1;
    wait_idle();
    check("final_op_count", op_count, 300 % 256);
    check("final_queue_empty", q.size(), 0);
    check("final_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
